// File: rtl/simple_circuit_checker_if.sv
// simple_circuit_checker_if: control, stimulus and result signals of the exhaustive 3-input circuit checker
interface simple_circuit_checker_if;
    logic       start;
    logic       a_o;
    logic       b_o;
    logic       c_o;
    logic       f_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_vec;

    modport master (
        output start, f_i,
        input  a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, f_i,
        output a_o, b_o, c_o, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/simple_circuit_checker.sv
// simple_circuit_checker: drives all 8 patterns onto a 3-input circuit and compares f against (a & b) | ~c
module simple_circuit_checker #(
    parameter int SETTLE = 2
) (
    input logic clk,
    input logic rst,
    simple_circuit_checker_if.slave bus
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DRIVE       = 3'd1;
    localparam logic [2:0] SETTLE_WAIT = 3'd2;
    localparam logic [2:0] SAMPLE      = 3'd3;
    localparam logic [2:0] FINISH      = 3'd4;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [7:0] fail_q, fail_d;
    logic       pass_q, pass_d;
    logic       exp_f;
    logic       busy;

    // Sequencer: step idx through 0..7, hold each pattern SETTLE cycles, then compare f_i with the reference function
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        exp_f   = (idx_q[2] & idx_q[1]) | ~idx_q[0];
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    idx_d   = 3'd0;
                    err_d   = 4'd0;
                    fail_d  = 8'd0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d   = SETTLE_LOAD;
                state_d = (SETTLE == 1) ? SAMPLE : SETTLE_WAIT;
            end
            SETTLE_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_d == 4'd0) ? SAMPLE : SETTLE_WAIT;
            end
            SAMPLE: begin
                if (bus.f_i != exp_f) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = err_q + 4'd1;
                end
                if (idx_q == 3'd7) begin
                    state_d = FINISH;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = DRIVE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset aborts any run and clears all results
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            err_q   <= 4'd0;
            fail_q  <= 8'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign busy                        = (state_q == DRIVE) || (state_q == SETTLE_WAIT) || (state_q == SAMPLE);
    assign {bus.a_o, bus.b_o, bus.c_o} = busy ? idx_q : 3'd0;
    assign bus.busy                    = busy;
    assign bus.done                    = (state_q == FINISH);
    assign bus.pass                    = pass_q;
    assign bus.err_count               = err_q;
    assign bus.fail_vec                = fail_q;
endmodule

// File: tb/tb_simple_circuit_checker.sv
// tb_simple_circuit_checker: scoreboard bench for the checker with SETTLE=2 and SETTLE=1 instances
module tb_simple_circuit_checker;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   mode0 = 0;
    int   mode1 = 0;
    int   bc0 = 0;
    int   bc1 = 0;

    typedef struct packed {
        logic [3:0] err;
        logic [7:0] fail;
        logic       pass;
        int         cycles;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    simple_circuit_checker_if bus0();
    simple_circuit_checker_if bus1();

    simple_circuit_checker #(.SETTLE(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    simple_circuit_checker #(.SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // mode 0: correct circuit, 1: output stuck at 1, 2: output stuck at 0
    function automatic logic fmodel(input int m, input logic a, input logic b, input logic c);
        return (m == 0) ? ((a & b) | ~c) : (m == 1);
    endfunction

    assign bus0.f_i = fmodel(mode0, bus0.a_o, bus0.b_o, bus0.c_o);
    assign bus1.f_i = fmodel(mode1, bus1.a_o, bus1.b_o, bus1.c_o);

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic done_check(input string tag, input exp_t e, input logic [3:0] err,
                              input logic [7:0] fail, input logic pass, input int cyc);
        check({tag, "_err_count"}, int'(err), int'(e.err));
        check({tag, "_fail_vec"}, int'(fail), int'(e.fail));
        check({tag, "_pass"}, int'(pass), int'(e.pass));
        check({tag, "_busy_cycles"}, cyc, e.cycles);
    endtask

    // Monitor for the SETTLE=2 instance: pop expected result on each done pulse
    always @(negedge clk) begin
        if (bus0.done) begin
            if (q0.size() == 0) check("dut0_unexpected_done", 1, 0);
            else done_check("dut0", q0.pop_front(), bus0.err_count, bus0.fail_vec, bus0.pass, bc0);
        end
        bc0 <= bus0.busy ? bc0 + 1 : 0;
    end

    // Monitor for the SETTLE=1 instance
    always @(negedge clk) begin
        if (bus1.done) begin
            if (q1.size() == 0) check("dut1_unexpected_done", 1, 0);
            else done_check("dut1", q1.pop_front(), bus1.err_count, bus1.fail_vec, bus1.pass, bc1);
        end
        bc1 <= bus1.busy ? bc1 + 1 : 0;
    end

    task automatic pulse(input int which);
        if (which == 0) bus0.start = 1'b1;
        else bus1.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        while (!((which == 0) ? bus0.done : bus1.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_done_timeout", 1, 0);
    endtask

    function automatic int outs0();
        return int'({bus0.a_o, bus0.b_o, bus0.c_o, bus0.busy, bus0.done, bus0.pass, bus0.err_count, bus0.fail_vec});
    endfunction

    initial begin
        rst = 1'b1;
        bus0.start = 1'b1;
        bus1.start = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        check("reset_dut0", outs0(), 0);
        check("reset_dut1", int'({bus1.a_o, bus1.b_o, bus1.c_o, bus1.busy, bus1.done, bus1.pass,
                                  bus1.err_count, bus1.fail_vec}), 0);
        @(negedge clk);
        check("idle_after_reset", int'(bus0.busy), 0);

        mode0 = 0;
        q0.push_back('{4'd0, 8'h00, 1'b1, 24});
        pulse(0);
        wait_done(0, 100);
        repeat (3) @(negedge clk);
        check("hold_pass", int'(bus0.pass), 1);
        check("hold_idle_outs", int'({bus0.a_o, bus0.b_o, bus0.c_o, bus0.busy}), 0);

        mode0 = 1;
        q0.push_back('{4'd3, 8'h2A, 1'b0, 24});
        pulse(0);
        wait_done(0, 100);
        repeat (2) @(negedge clk);
        check("hold_fail_vec", int'(bus0.fail_vec), 'h2A);

        mode0 = 2;
        q0.push_back('{4'd5, 8'hD5, 1'b0, 24});
        pulse(0);
        wait_done(0, 100);
        repeat (2) @(negedge clk);

        mode1 = 0;
        q1.push_back('{4'd0, 8'h00, 1'b1, 16});
        pulse(1);
        for (int k = 0; k < 16; k++) begin
            check("settle1_pattern", int'({bus1.a_o, bus1.b_o, bus1.c_o, bus1.busy}), ((k / 2) << 1) | 1);
            @(negedge clk);
        end
        check("settle1_end_busy", int'({bus1.busy, bus1.done}), 1);
        repeat (2) @(negedge clk);

        mode0 = 0;
        pulse(0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outs", outs0(), 0);
        @(negedge clk);
        check("abort_no_done", int'({bus0.busy, bus0.done}), 0);

        mode0 = 1;
        q0.push_back('{4'd3, 8'h2A, 1'b0, 24});
        pulse(0);
        check("restart_idx0", int'({bus0.a_o, bus0.b_o, bus0.c_o, bus0.busy}), 1);
        wait_done(0, 100);
        repeat (2) @(negedge clk);

        mode0 = 2;
        q0.push_back('{4'd5, 8'hD5, 1'b0, 24});
        pulse(0);
        repeat (3) @(negedge clk);
        pulse(0);
        wait_done(0, 100);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        check("finish_start_ignored", int'(bus0.busy), 0);
        @(negedge clk);
        check("still_idle", int'({bus0.busy, bus0.done}), 0);
        check("results_unchanged", int'(bus0.err_count), 5);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/simple_circuit_checker.md
SIMPLE_CIRCUIT_CHECKER -- requirements
Module: simple_circuit_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of clk cycles a pattern is held before f_i is sampled; legal range 1..15.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a full check run.
REQ-005 Port: a_o  output  1  drive value for the circuit-under-test input a.
REQ-006 Port: b_o  output  1  drive value for the circuit-under-test input b.
REQ-007 Port: c_o  output  1  drive value for the circuit-under-test input c.
REQ-008 Port: f_i  input  1  circuit-under-test output f, treated as combinational from a_o/b_o/c_o.
REQ-009 Port: busy  output  1  high while a run is in progress.
REQ-010 Port: done  output  1  one-cycle pulse when a run completes.
REQ-011 Port: pass  output  1  high after a run with zero mismatches; held until next start or rst.
REQ-012 Port: err_count  output  4  number of mismatching patterns in the last run (0..8).
REQ-013 Port: fail_vec  output  8  bit i set when pattern i mismatched in the last run.

Function
REQ-014 Pattern index idx is 3 bits; {a_o,b_o,c_o} SHALL equal idx (a_o = MSB) while busy.
REQ-015 Expected value for pattern idx SHALL be exp = (a & b) | ~c, computed internally from idx.
REQ-016 FSM states: IDLE, DRIVE, SETTLE_WAIT, SAMPLE, FINISH.
REQ-017 IDLE: busy=0; start=1 -> DRIVE, idx<=0, err_count<=0, fail_vec<=0, pass<=0.
REQ-018 DRIVE: outputs present idx; settle counter loaded with SETTLE-1; -> SETTLE_WAIT (or SAMPLE if SETTLE=1).
REQ-019 SETTLE_WAIT: counter decrements each cycle; counter=0 -> SAMPLE.
REQ-020 SAMPLE: f_i compared to exp; mismatch -> fail_vec[idx]<=1, err_count<=err_count+1.
REQ-021 SAMPLE with idx=7 -> FINISH; otherwise idx<=idx+1 and -> DRIVE.
REQ-022 Each pattern occupies exactly SETTLE+1 cycles (DRIVE + SETTLE-1 waits + SAMPLE); full run 8*(SETTLE+1) busy cycles.
REQ-023 FINISH: done=1 for exactly one cycle, pass<=(err_count==0 including final sample), busy=0 in FINISH, -> IDLE.
REQ-024 start while busy SHALL be ignored; no restart, no counter change.
REQ-025 start asserted in the FINISH cycle SHALL be ignored; start in the following IDLE cycle starts a new run.
REQ-026 idx SHALL NOT wrap; run terminates after idx=7 sample.
REQ-027 In IDLE and FINISH, a_o/b_o/c_o SHALL be 0.
REQ-028 err_count, fail_vec, pass SHALL hold last-run results in IDLE until next accepted start.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE; a_o=b_o=c_o=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-030 rst mid-run SHALL abort the run without a done pulse; rst has priority over start in the same cycle.

Verification
REQ-031 SETTLE=2, f_i driven by correct (a&b)|~c model, start pulse -> busy 24 cycles, done pulse once, pass=1, err_count=0, fail_vec=8'h00.
REQ-032 f_i stuck at 1 -> mismatches at idx 1,3,5 (exp=0) -> err_count=3, fail_vec=8'h2A, pass=0.
REQ-033 f_i stuck at 0 -> err_count=5, fail_vec=8'hD5, pass=0.
REQ-034 SETTLE=1, correct model -> busy exactly 16 cycles, sequence on {a_o,b_o,c_o} 0..7 each held 2 cycles.
REQ-035 rst asserted at 10th busy cycle -> next cycle all outputs at reset values, no done pulse; subsequent start runs full sequence from idx 0.
REQ-036 start re-pulsed at busy cycle 5 and in FINISH cycle -> ignored, single done pulse, results unchanged.
